// File: rtl/mem_access_unit.sv
// MAR/MDR memory-access unit: holds the address and data registers and runs
// single read/write transactions against a fixed-latency synchronous RAM.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no transaction; MAR/MDR loadable from the bus, requests accepted
//   RD_WAIT | read in flight; count_q edges remain before MDR captures RAM data
//   WR      | write strobe cycle; mem_wren_o is high for exactly this cycle
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int MEM_LAT = 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] bus_mux_out_i,
    input  logic              mar_in_i,
    input  logic              mdr_in_i,
    input  logic              mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [ADDR_W-1:0] mar_data_out_o,
    output logic [DATA_W-1:0] mdr_data_out_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_wren_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   mar_q, mar_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic                wren_q, wren_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            count_q <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            wren_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            wren_q  <= wren_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: MAR/MDR only change in IDLE or on read completion.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        wren_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mar_in_i) mar_d = bus_mux_out_i[ADDR_W-1:0];
                if (mdr_in_i) mdr_d = bus_mux_out_i;
                if (mem_rd_i && mem_wr_i) begin
                    err_d = 1'b1;
                end else if (mem_rd_i) begin
                    state_d = RD_WAIT;
                    count_d = CNT_W'(MEM_LAT - 1);
                end else if (mem_wr_i) begin
                    state_d = WR;
                    wren_d  = 1'b1;
                end
            end
            RD_WAIT: begin
                if (mem_rd_i || mem_wr_i) err_d = 1'b1;
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end else begin
                    mdr_d   = mem_rdata_i;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WR: begin
                if (mem_rd_i || mem_wr_i) err_d = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mar_data_out_o = mar_q;
    assign mdr_data_out_o = mdr_q;
    assign mem_addr_o     = mar_q;
    assign mem_wdata_o    = mdr_q;
    assign mem_wren_o     = wren_q;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = done_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus tasks push expected Done/Err
// events into queues, an independent monitor pops and compares them.
module tb_mem_access_unit;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 9;
    localparam int MEM_LAT = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] bus = '0;
    logic              mar_in = 1'b0, mdr_in = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mar_out, mem_addr;
    logic [DATA_W-1:0] mdr_out, mem_wdata;
    logic              mem_wren, busy, done, err;

    mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
        .clock_i(clk), .reset_i(rst), .bus_mux_out_i(bus),
        .mar_in_i(mar_in), .mdr_in_i(mdr_in), .mem_rd_i(mem_rd), .mem_wr_i(mem_wr),
        .mem_rdata_i(mem_rdata), .mar_data_out_o(mar_out), .mdr_data_out_o(mdr_out),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wren_o(mem_wren),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    function automatic logic [31:0] init_val(input logic [ADDR_W-1:0] a);
        return 32'h9E3779B9 * ({23'b0, a} + 32'd1);
    endfunction

    // Environment RAM: registered read, contents defined by init_val until written.
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    bit                ram_wr [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
        if (mem_wren) begin
            ram[mem_addr]    <= mem_wdata;
            ram_wr[mem_addr] <= 1'b1;
        end
    end

    // Reference model state.
    logic [ADDR_W-1:0] mar_m = '0;
    logic [DATA_W-1:0] mdr_m = '0;
    logic [DATA_W-1:0] ram_m [0:(1<<ADDR_W)-1];
    bit                ram_m_wr [0:(1<<ADDR_W)-1];

    function automatic logic [31:0] model_read(input logic [ADDR_W-1:0] a);
        return ram_m_wr[a] ? ram_m[a] : init_val(a);
    endfunction

    logic [DATA_W-1:0] exp_done_q [$];
    int                exp_err_q [$];
    int                done_seen = 0, err_seen = 0, done_exp = 0, err_exp = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Monitor: every Done/Err pulse must match a pending expectation.
    initial begin
        logic [DATA_W-1:0] e;
        forever begin
            @(negedge clk);
            if (done) begin
                done_seen++;
                if (exp_done_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_done_q.pop_front();
                    chk("done_mdr", mdr_out, e);
                    chk("done_busy", {31'b0, busy}, 32'd0);
                end
            end
            if (err) begin
                err_seen++;
                if (exp_err_q.size() == 0) chk("unexpected_err", 32'd1, 32'd0);
                else void'(exp_err_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mar(input logic [31:0] v);
        bus = v; mar_in = 1'b1;
        step();
        mar_in = 1'b0;
        mar_m = v[ADDR_W-1:0];
        chk("mar_load", {23'b0, mar_out}, {23'b0, mar_m});
        chk("mem_addr_eq_mar", {23'b0, mem_addr}, {23'b0, mar_m});
    endtask

    task automatic load_mdr(input logic [31:0] v);
        bus = v; mdr_in = 1'b1;
        step();
        mdr_in = 1'b0;
        mdr_m = v;
        chk("mdr_load", mdr_out, mdr_m);
    endtask

    task automatic do_read(input bit disturb);
        int cyc;
        mem_rd = 1'b1;
        step();
        mem_rd = 1'b0;
        mdr_m = model_read(mar_m);
        exp_done_q.push_back(mdr_m); done_exp++;
        cyc = 0;
        while (busy && cyc < 20) begin
            if (disturb && cyc == 0) begin
                mem_wr = 1'b1; mar_in = 1'b1; bus = 32'h0000_0055;
                exp_err_q.push_back(1); err_exp++;
            end
            if (disturb && cyc == MEM_LAT - 1) begin
                mdr_in = 1'b1; bus = $urandom;
            end
            cyc++;
            step();
            mem_wr = 1'b0; mar_in = 1'b0; mdr_in = 1'b0;
            if (busy) chk("mar_stable", {23'b0, mar_out}, {23'b0, mar_m});
        end
        chk("read_busy_cycles", cyc, MEM_LAT);
        chk("read_mar_after", {23'b0, mar_out}, {23'b0, mar_m});
    endtask

    task automatic do_write();
        mem_wr = 1'b1;
        step();
        mem_wr = 1'b0;
        chk("wr_wren_hi", {31'b0, mem_wren}, 32'd1);
        chk("wr_addr", {23'b0, mem_addr}, {23'b0, mar_m});
        chk("wr_wdata", mem_wdata, mdr_m);
        chk("wr_busy", {31'b0, busy}, 32'd1);
        exp_done_q.push_back(mdr_m); done_exp++;
        ram_m[mar_m] = mdr_m; ram_m_wr[mar_m] = 1'b1;
        step();
        chk("wr_wren_lo", {31'b0, mem_wren}, 32'd0);
        chk("wr_busy_lo", {31'b0, busy}, 32'd0);
    endtask

    task automatic do_both();
        mem_rd = 1'b1; mem_wr = 1'b1;
        exp_err_q.push_back(1); err_exp++;
        step();
        mem_rd = 1'b0; mem_wr = 1'b0;
        chk("both_busy", {31'b0, busy}, 32'd0);
        chk("both_wren", {31'b0, mem_wren}, 32'd0);
        step();
        chk("both_wren2", {31'b0, mem_wren}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            ram_m_wr[i] = 1'b0;
            ram_wr[i]   = 1'b0;
        end
        step(); step();
        chk("rst_mar", {23'b0, mar_out}, 32'd0);
        chk("rst_mdr", mdr_out, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done_err_wren", {29'b0, done, err, mem_wren}, 32'd0);
        rst = 1'b0;
        step();

        load_mar(32'hFFFF_F005);
        chk("mar_trunc", {23'b0, mar_out}, 32'h005);

        load_mar(32'h0000_000A);
        load_mdr(32'hDEAD_BEEF);
        do_write();
        load_mdr(32'h0);
        do_read(1'b0);
        chk("read_deadbeef", mdr_out, 32'hDEAD_BEEF);

        load_mdr(32'h1234_5678);
        load_mar(32'h0000_01FF);
        do_write();
        load_mdr(32'h0);
        do_read(1'b0);
        chk("readback_12345678", mdr_out, 32'h1234_5678);

        load_mar(32'h0000_000A);
        do_read(1'b1);
        chk("disturbed_read", mdr_out, 32'hDEAD_BEEF);

        do_both();

        // Reset during the second cycle of a read aborts it silently.
        load_mar(32'h0000_01FF);
        mem_rd = 1'b1;
        step();
        mem_rd = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mar_m = '0; mdr_m = '0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_mdr", mdr_out, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        step(); step();
        chk("abort_mdr_later", mdr_out, 32'd0);

        load_mar(32'h0000_000A);
        do_read(1'b0);
        do_write();

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0: load_mar($urandom);
                1: load_mdr($urandom);
                2: do_read(1'b0);
                3: do_write();
                4: do_read(1'b1);
                default: do_both();
            endcase
        end

        step(); step();
        chk("done_count", done_seen, done_exp);
        chk("err_count", err_seen, err_exp);
        chk("done_queue_empty", exp_done_q.size(), 32'd0);
        chk("err_queue_empty", exp_err_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
